// File: rtl/hs_sync_rx_if.sv
// hs_sync_rx_if: bundled-data pipeline tail and valid/ready stream bundle.
// Ports: req_in/data_in/ack_in (4-phase side), dout/dout_valid/dout_ready/level (sync side).
interface hs_sync_rx_if #(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              req_in;
    logic [DATA_W-1:0] data_in;
    logic              ack_in;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic [LVL_W-1:0]  level;

    modport master (
        output req_in, data_in, dout_ready,
        input  ack_in, dout, dout_valid, level
    );

    modport slave (
        input  req_in, data_in, dout_ready,
        output ack_in, dout, dout_valid, level
    );
endinterface

// File: rtl/hs_sync_rx.sv
// hs_sync_rx: clocked 4-phase receiver buffering tokens into a FIFO stream.
// Ports: clk, rst_n (async low), bus (slave: req_in/data_in/ack_in, dout/dout_valid/dout_ready/level).
module hs_sync_rx #(
    parameter int DATA_W      = 3,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    hs_sync_rx_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic                   ack_q, ack_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [DATA_W-1:0]      mem_q [DEPTH];
    logic [DATA_W-1:0]      mem_d [DEPTH];

    logic req_s;
    logic full;
    logic push;
    logic pop;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], bus.req_in};
        req_s    = sync_q[SYNC_STAGES-1];
        // Full is judged on the pre-pop level: a pop and a push never
        // share an edge when the FIFO is full.
        full     = (level_q == LVL_W'(DEPTH));
        pop      = (level_q != '0) && bus.dout_ready;
        push     = 1'b0;
        state_d  = state_q;
        ack_d    = ack_q;
        mem_d    = mem_q;

        unique case (state_q)
            IDLE: begin
                if (req_s && !full) begin
                    push    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACKED;
                end
            end
            ACKED: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
            end
        endcase

        // data_in is only sampled here, under the bundling guarantee.
        if (push) begin
            mem_d[wr_ptr_q] = bus.data_in;
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push && pop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            sync_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            sync_q   <= sync_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            mem_q    <= mem_d;
        end
    end

    assign bus.ack_in     = ack_q;
    assign bus.dout       = mem_q[rd_ptr_q];
    assign bus.dout_valid = (level_q != '0);
    assign bus.level      = level_q;
endmodule
